ca_gen_sequencer: RTL and testbench
===================================

// Module: ca_gen_sequencer
// PURPOSE
//  Command-driven controller for the serial 1-D cellular-automaton update engine.
//  Accepts a job (rule, seed row, generation count) and loads the engine.
//  Steps the engine one generation at a time and streams every generation row
//  (seed first) on a valid/ready output with backpressure. Sits between the host/
//  command fabric and the CA engine, which is a sweep-serial cell updater.
// PARAMETERS
//  ACTIVE_CELL  128   cells per row (engine boundary cells excluded)
//  GEN_W        16    width of generation count / index
//  TIMEOUT      1024  max cycles in WAIT for eng_done before abort (>=2)
// PORTS
//  clk        in   1            clock; all logic on posedge
//  reset      in   1            synchronous, active-high reset
//  cmd_valid  in   1            job request
//  cmd_ready  out  1            high only in IDLE
//  cmd_rule   in   8            Wolfram rule number (next = rule[{L,C,R}])
//  cmd_seed   in   ACTIVE_CELL  generation-0 row
//  cmd_gens   in   GEN_W        generations to compute after seed (0 = seed only)
//  abort      in   1            cancel current job
//  eng_load   out  1            1-cycle pulse: engine loads eng_rule/eng_seed
//  eng_rule   out  8            latched rule, stable from LOAD to next job
//  eng_seed   out  ACTIVE_CELL  latched seed, stable from LOAD to next job
//  eng_step   out  1            1-cycle pulse: engine performs one full sweep
//  eng_done   in   1            1-cycle pulse: sweep finished, eng_state valid
//  eng_state  in   ACTIVE_CELL  engine row, sampled only when eng_done=1 in WAIT
//  row_valid  out  1            generation row available
//  row_ready  in   1            consumer accepts row
//  row_data   out  ACTIVE_CELL  generation row
//  row_gen    out  GEN_W        generation index of row_data (0 = seed)
//  row_last   out  1            row_gen == latched cmd_gens
//  busy       out  1            state != IDLE
//  err_timeout out 1            sticky: engine missed eng_done within TIMEOUT
// BEHAVIOUR
//  Reset: state=IDLE; cmd_ready=1; all other outputs 0 (incl. eng_rule/seed,
//   row_data, row_gen, err_timeout). reset overrides abort and all handshakes.
//  FSM: IDLE -> LOAD -> EMIT -> {STEP -> WAIT -> EMIT}* -> IDLE.
//  IDLE: cmd_valid&cmd_ready latches rule/seed/gens, gen_cnt:=0, clears
//   err_timeout, -> LOAD. row_data:=cmd_seed.
//  LOAD (1 cycle): eng_load=1 -> EMIT. Accept at T => eng_load at T+1,
//   row_valid first high at T+2.
//  EMIT: row_valid=1; row_data/row_gen/row_last held stable until accepted.
//   On row_ready: row_last -> IDLE (cmd_ready=1 next cycle); else -> STEP.
//  STEP (1 cycle): eng_step=1, gen_cnt+=1, timer:=0 -> WAIT.
//  WAIT: timer+=1 each cycle. On eng_done: row_data:=eng_state,
//   row_gen:=gen_cnt -> EMIT (row_valid next cycle). If timer==TIMEOUT-1
//   and no eng_done: err_timeout:=1 -> IDLE, no row emitted.
//   eng_done and timeout same cycle: eng_done wins.
//  eng_done outside WAIT: ignored, no state change.
//  abort (any non-IDLE state): -> IDLE next cycle; row_valid drops without
//   handshake (only allowed exception); no eng_* pulse issued that cycle;
//   err_timeout unchanged. abort in IDLE: no effect; cmd accept that cycle is
//   suppressed (cmd_ready=0 while abort=1).
//  Widths: gen_cnt is GEN_W bits; max job = 2^GEN_W-1 gens, never wraps since
//   gen_cnt stops at cmd_gens. Rows per job = cmd_gens+1.
//  eng_load and eng_step never high in the same cycle; at most one of each per
//   generation; eng_step never issued while row_valid=1.
//  Throughput: per generation >= 3 + engine sweep latency cycles.
// TESTING
//  1 rule=182, seed=1<<64, gens=0 -> one row, row_gen=0, row_last=1,
//    row_data=seed; no eng_step; cmd_ready high 1 cycle after accept.
//  2 rule=90, seed=1<<64, gens=3, engine model done 130 cyc after step ->
//    rows gen0..3, gen1 = bits 63,65 set; row_last only on gen3.
//  3 Case 2 with row_ready held low 50 cyc at gen1 -> row_data/row_gen stable,
//    eng_step not pulsed until accept; same row sequence.
//  4 Model never asserts eng_done, TIMEOUT=1024 -> err_timeout=1 exactly 1024
//    cyc after eng_step; IDLE; err_timeout clears on next cmd accept.
//  5 abort pulse in WAIT and in EMIT -> IDLE next cycle, row_valid=0,
//    busy=0; stray eng_done afterwards ignored; next job runs normally.
//  6 reset asserted mid-job (WAIT) together with abort -> all outputs at reset
//    values next cycle; cmd_valid held high accepted once reset deasserts.

Source files
------------

// File: rtl/ca_gen_sequencer_if.sv
// rtl/ca_gen_sequencer_if.sv - command, engine and row-stream signal bundle for ca_gen_sequencer
interface ca_gen_sequencer_if #(
    parameter int ACTIVE_CELL = 128,
    parameter int GEN_W       = 16
);
    // host command channel
    logic                   cmd_valid;
    logic                   cmd_ready;
    logic [7:0]             cmd_rule;
    logic [ACTIVE_CELL-1:0] cmd_seed;
    logic [GEN_W-1:0]       cmd_gens;
    logic                   abort;

    // CA engine control and result
    logic                   eng_load;
    logic [7:0]             eng_rule;
    logic [ACTIVE_CELL-1:0] eng_seed;
    logic                   eng_step;
    logic                   eng_done;
    logic [ACTIVE_CELL-1:0] eng_state;

    // generation row stream
    logic                   row_valid;
    logic                   row_ready;
    logic [ACTIVE_CELL-1:0] row_data;
    logic [GEN_W-1:0]       row_gen;
    logic                   row_last;

    // status
    logic                   busy;
    logic                   err_timeout;

    // environment side: host, engine and row consumer
    modport master (
        output cmd_valid, cmd_rule, cmd_seed, cmd_gens, abort,
        output eng_done, eng_state,
        output row_ready,
        input  cmd_ready,
        input  eng_load, eng_rule, eng_seed, eng_step,
        input  row_valid, row_data, row_gen, row_last,
        input  busy, err_timeout
    );

    // sequencer side
    modport slave (
        input  cmd_valid, cmd_rule, cmd_seed, cmd_gens, abort,
        input  eng_done, eng_state,
        input  row_ready,
        output cmd_ready,
        output eng_load, eng_rule, eng_seed, eng_step,
        output row_valid, row_data, row_gen, row_last,
        output busy, err_timeout
    );
endinterface

// File: rtl/ca_gen_sequencer.sv
// rtl/ca_gen_sequencer.sv - job sequencer that loads, steps and streams rows of a 1-D CA engine
module ca_gen_sequencer #(
    parameter int ACTIVE_CELL = 128,
    parameter int GEN_W       = 16,
    parameter int TIMEOUT     = 1024
) (
    input  logic              clk,
    input  logic              reset,
    ca_gen_sequencer_if.slave bus
);
    // timer only needs to reach TIMEOUT-1, the last cycle eng_done is still honoured
    localparam int TIMER_W = $clog2(TIMEOUT);
    localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_EMIT,
        S_STEP,
        S_WAIT
    } state_t;

    state_t                 state;
    logic                   eng_load_q;
    logic                   eng_step_q;
    logic [7:0]             rule_q;
    logic [ACTIVE_CELL-1:0] seed_q;
    logic [GEN_W-1:0]       gens_q;
    logic [GEN_W-1:0]       gen_cnt;
    logic [TIMER_W-1:0]     timer;
    logic                   row_valid_q;
    logic [ACTIVE_CELL-1:0] row_data_q;
    logic [GEN_W-1:0]       row_gen_q;
    logic                   row_last_q;
    logic                   err_q;

    logic                   cmd_ready_w;
    logic                   cmd_accept;
    logic                   row_accept;

    // a pending abort blocks a new job in the same cycle it is requested
    assign cmd_ready_w = (state == S_IDLE) && !bus.abort;
    assign cmd_accept  = bus.cmd_valid && cmd_ready_w;
    assign row_accept  = row_valid_q && bus.row_ready;

    assign bus.cmd_ready   = cmd_ready_w;
    assign bus.busy        = (state != S_IDLE);
    assign bus.eng_load    = eng_load_q;
    assign bus.eng_step    = eng_step_q;
    assign bus.eng_rule    = rule_q;
    assign bus.eng_seed    = seed_q;
    assign bus.row_valid   = row_valid_q;
    assign bus.row_data    = row_data_q;
    assign bus.row_gen     = row_gen_q;
    assign bus.row_last    = row_last_q;
    assign bus.err_timeout = err_q;

    // job FSM: IDLE -> LOAD -> EMIT -> {STEP -> WAIT -> EMIT}* -> IDLE, all outputs registered
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= S_IDLE;
            eng_load_q  <= 1'b0;
            eng_step_q  <= 1'b0;
            rule_q      <= '0;
            seed_q      <= '0;
            gens_q      <= '0;
            gen_cnt     <= '0;
            timer       <= '0;
            row_valid_q <= 1'b0;
            row_data_q  <= '0;
            row_gen_q   <= '0;
            row_last_q  <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            eng_load_q <= 1'b0;
            eng_step_q <= 1'b0;

            if (bus.abort && (state != S_IDLE)) begin
                // cancel: drop the row without handshake, launch no engine pulse
                state       <= S_IDLE;
                row_valid_q <= 1'b0;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (cmd_accept) begin
                            rule_q     <= bus.cmd_rule;
                            seed_q     <= bus.cmd_seed;
                            gens_q     <= bus.cmd_gens;
                            gen_cnt    <= '0;
                            err_q      <= 1'b0;
                            row_data_q <= bus.cmd_seed;
                            row_gen_q  <= '0;
                            row_last_q <= (bus.cmd_gens == '0);
                            eng_load_q <= 1'b1;
                            state      <= S_LOAD;
                        end
                    end

                    S_LOAD: begin
                        // seed row is already in row_data, offer it next
                        row_valid_q <= 1'b1;
                        state       <= S_EMIT;
                    end

                    S_EMIT: begin
                        if (row_accept) begin
                            row_valid_q <= 1'b0;
                            if (row_last_q) begin
                                state <= S_IDLE;
                            end else begin
                                eng_step_q <= 1'b1;
                                state      <= S_STEP;
                            end
                        end
                    end

                    S_STEP: begin
                        gen_cnt <= gen_cnt + GEN_W'(1);
                        timer   <= '0;
                        state   <= S_WAIT;
                    end

                    S_WAIT: begin
                        // eng_done takes priority over an expiring timer
                        if (bus.eng_done) begin
                            row_data_q  <= bus.eng_state;
                            row_gen_q   <= gen_cnt;
                            row_last_q  <= (gen_cnt == gens_q);
                            row_valid_q <= 1'b1;
                            state       <= S_EMIT;
                        end else if (timer == TIMER_LAST) begin
                            err_q <= 1'b1;
                            state <= S_IDLE;
                        end else begin
                            timer <= timer + TIMER_W'(1);
                        end
                    end

                    default: begin
                        state       <= S_IDLE;
                        row_valid_q <= 1'b0;
                    end
                endcase
            end
        end
    end
endmodule

// File: tb/tb_ca_gen_sequencer.sv
// tb/tb_ca_gen_sequencer.sv - self-checking bench for ca_gen_sequencer
module tb_ca_gen_sequencer;
    localparam int N  = 128;
    localparam int GW = 16;
    localparam int TO = 1024;

    typedef struct {
        logic [N-1:0]  data;
        logic [GW-1:0] gen;
        logic          last;
    } row_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    ca_gen_sequencer_if #(.ACTIVE_CELL(N), .GEN_W(GW)) ifc ();

    ca_gen_sequencer #(.ACTIVE_CELL(N), .GEN_W(GW), .TIMEOUT(TO)) dut (
        .clk   (clk),
        .reset (rst),
        .bus   (ifc)
    );

    int n_total = 0;
    int n_pass  = 0;
    int cyc     = 0;
    row_t exp_q[$];
    logic [N-1:0] acc_data [8];

    // engine model state
    int   eng_lat   = 130;
    bit   eng_never = 1'b0;
    int   steps     = 0;
    int   stray_req = 0;
    int   stray_ack = 0;
    int   cd        = 0;
    logic [7:0]   e_rule;
    logic [N-1:0] e_row;
    logic e_st, e_ld, e_rs;

    // consumer model state
    int stall_gen  = -1;
    int stall_left = 0;
    bit rv_prev    = 1'b0;

    // compare-process state
    bit            prev_hold = 1'b0;
    logic [N-1:0]  prev_data;
    logic [GW-1:0] prev_gen;
    logic          prev_last;
    int            last_step_cyc = 0;

    task automatic chk(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    endtask

    // one generation of an elementary CA with zero boundary cells; bit i+1 is the left neighbour
    function automatic logic [N-1:0] ca_next(input logic [7:0] rule, input logic [N-1:0] row);
        logic [N-1:0] nx;
        logic l, r;
        for (int i = 0; i < N; i++) begin
            l = 1'b0;
            r = 1'b0;
            if (i < N - 1) l = row[i+1];
            if (i > 0)     r = row[i-1];
            nx[i] = rule[{l, row[i], r}];
        end
        return nx;
    endfunction

    // expected rows 0..upto of a job with the given generation count
    task automatic push_job(input logic [7:0] rule, input logic [N-1:0] seed, input int gens, input int upto);
        logic [N-1:0] cur;
        row_t e;
        cur = seed;
        for (int g = 0; g <= upto; g++) begin
            e.data = cur;
            e.gen  = GW'(g);
            e.last = (g == gens);
            exp_q.push_back(e);
            cur = ca_next(rule, cur);
        end
    endtask

    always @(posedge clk) cyc++;

    // engine: latch on load, answer each step with the next generation after eng_lat cycles
    always @(posedge clk) begin
        e_st = ifc.eng_step;
        e_ld = ifc.eng_load;
        e_rs = rst;
        #1;
        ifc.eng_done = 1'b0;
        if (e_rs) begin
            cd = 0;
        end else begin
            if (e_ld) begin
                e_rule = ifc.eng_rule;
                e_row  = ifc.eng_seed;
                cd     = 0;
            end
            if (cd > 0) begin
                cd--;
                if (cd == 0) begin
                    e_row         = ca_next(e_rule, e_row);
                    ifc.eng_state = e_row;
                    ifc.eng_done  = 1'b1;
                end
            end
            if (e_st) begin
                steps++;
                if (!eng_never) cd = eng_lat;
            end
            if (stray_req != stray_ack) begin
                stray_ack     = stray_req;
                ifc.eng_state = '1;
                ifc.eng_done  = 1'b1;
            end
        end
    end

    // consumer: ready by default, holds ready low 50 cycles when the chosen generation appears
    always @(posedge clk) begin
        #1;
        if (stall_left > 0) begin
            stall_left--;
            ifc.row_ready = (stall_left == 0);
        end else begin
            ifc.row_ready = 1'b1;
            if (ifc.row_valid && !rv_prev && stall_gen >= 0 && int'(ifc.row_gen) == stall_gen) begin
                stall_left    = 50;
                ifc.row_ready = 1'b0;
            end
        end
        rv_prev = ifc.row_valid;
    end

    // compare process: protocol rules every cycle, row contents against the model on each transfer
    always @(negedge clk) begin
        if (rst) begin
            prev_hold = 1'b0;
        end else begin
            chk("load_step_excl", N'(ifc.eng_load & ifc.eng_step), '0);
            chk("step_while_valid", N'(ifc.eng_step & ifc.row_valid), '0);
            chk("cmd_ready_rule", N'(ifc.cmd_ready), N'(!ifc.busy && !ifc.abort));
            if (prev_hold) begin
                chk("hold_valid", N'(ifc.row_valid), N'(1));
                chk("hold_data", ifc.row_data, prev_data);
                chk("hold_gen", N'(ifc.row_gen), N'(prev_gen));
                chk("hold_last", N'(ifc.row_last), N'(prev_last));
            end
            if (ifc.eng_step) last_step_cyc = cyc;
            if (ifc.row_valid && ifc.row_ready) begin
                if (exp_q.size() == 0) begin
                    n_total++;
                    $display("FAIL row_unexpected: actual=row gen %0d required=no row", ifc.row_gen);
                end else begin
                    row_t e;
                    e = exp_q.pop_front();
                    chk("row_data", ifc.row_data, e.data);
                    chk("row_gen", N'(ifc.row_gen), N'(e.gen));
                    chk("row_last", N'(ifc.row_last), N'(e.last));
                    if (int'(ifc.row_gen) < 8) acc_data[int'(ifc.row_gen)] = ifc.row_data;
                end
            end
            prev_hold = ifc.row_valid && !ifc.row_ready && !ifc.abort;
            prev_data = ifc.row_data;
            prev_gen  = ifc.row_gen;
            prev_last = ifc.row_last;
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_cmd_ready"}, N'(ifc.cmd_ready), N'(1));
        chk({tag, "_busy"}, N'(ifc.busy), '0);
        chk({tag, "_eng_load"}, N'(ifc.eng_load), '0);
        chk({tag, "_eng_step"}, N'(ifc.eng_step), '0);
        chk({tag, "_eng_rule"}, N'(ifc.eng_rule), '0);
        chk({tag, "_eng_seed"}, ifc.eng_seed, '0);
        chk({tag, "_row_valid"}, N'(ifc.row_valid), '0);
        chk({tag, "_row_data"}, ifc.row_data, '0);
        chk({tag, "_row_gen"}, N'(ifc.row_gen), '0);
        chk({tag, "_row_last"}, N'(ifc.row_last), '0);
        chk({tag, "_err_timeout"}, N'(ifc.err_timeout), '0);
    endtask

    // offer a job, then check the accept -> eng_load -> row_valid latency; called in the drive phase
    task automatic send_cmd(input string tag, input logic [7:0] rule, input logic [N-1:0] seed, input int gens);
        bit ok;
        ok = 1'b0;
        ifc.cmd_rule  = rule;
        ifc.cmd_seed  = seed;
        ifc.cmd_gens  = GW'(gens);
        ifc.cmd_valid = 1'b1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (ifc.cmd_ready) begin
                ok = 1'b1;
                break;
            end
        end
        chk({tag, "_accept"}, N'(ok), N'(1));
        @(posedge clk);
        #1;
        ifc.cmd_valid = 1'b0;
        @(negedge clk);
        chk({tag, "_load_t1"}, N'(ifc.eng_load), N'(1));
        chk({tag, "_err_clr_t1"}, N'(ifc.err_timeout), '0);
        chk({tag, "_busy_t1"}, N'(ifc.busy), N'(1));
        chk({tag, "_valid_t1"}, N'(ifc.row_valid), '0);
        chk({tag, "_rule_t1"}, N'(ifc.eng_rule), N'(rule));
        chk({tag, "_seed_t1"}, ifc.eng_seed, seed);
        @(negedge clk);
        chk({tag, "_valid_t2"}, N'(ifc.row_valid), N'(1));
        chk({tag, "_load_t2"}, N'(ifc.eng_load), '0);
        @(posedge clk);
        #1;
    endtask

    task automatic wait_done(input string tag, input int budget);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && !ifc.busy) begin
                ok = 1'b1;
                break;
            end
        end
        chk({tag, "_done"}, N'(ok), N'(1));
        @(posedge clk);
        #1;
    endtask

    task automatic wait_steps(input string tag, input int target, input int budget);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (steps >= target) begin
                ok = 1'b1;
                break;
            end
            tick(1);
        end
        chk({tag, "_step_seen"}, N'(ok), N'(1));
    endtask

    task automatic pulse_abort_and_check(input string tag);
        ifc.abort = 1'b1;
        tick(1);
        ifc.abort = 1'b0;
        exp_q.delete();
        @(negedge clk);
        chk({tag, "_row_valid"}, N'(ifc.row_valid), '0);
        chk({tag, "_busy"}, N'(ifc.busy), '0);
        chk({tag, "_cmd_ready"}, N'(ifc.cmd_ready), N'(1));
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [N-1:0] seed64, lit1, lit2, lit3, seed6;
        int s0, err_cyc;
        bit ok;

        seed64 = 128'd1 << 64;
        lit1   = (128'd1 << 63) | (128'd1 << 65);
        lit2   = (128'd1 << 62) | (128'd1 << 66);
        lit3   = (128'd1 << 61) | (128'd1 << 63) | (128'd1 << 65) | (128'd1 << 67);
        seed6  = 128'hF0 << 60;

        rst           = 1'b1;
        ifc.cmd_valid = 1'b0;
        ifc.cmd_rule  = '0;
        ifc.cmd_seed  = '0;
        ifc.cmd_gens  = '0;
        ifc.abort     = 1'b0;
        tick(3);
        rst = 1'b0;
        @(negedge clk);
        chk_reset_outputs("rst0");
        @(posedge clk);
        #1;

        // 1: seed-only job
        s0 = steps;
        push_job(8'd182, seed64, 0, 0);
        send_cmd("t1", 8'd182, seed64, 0);
        @(negedge clk);
        chk("t1_cmd_ready_after", N'(ifc.cmd_ready), N'(1));
        chk("t1_busy_after", N'(ifc.busy), '0);
        @(posedge clk);
        #1;
        chk("t1_seed_row", acc_data[0], seed64);
        chk("t1_no_step", N'(steps - s0), '0);

        // 2: rule 90, three generations
        s0 = steps;
        push_job(8'd90, seed64, 3, 3);
        send_cmd("t2", 8'd90, seed64, 3);
        wait_done("t2", 1500);
        chk("t2_gen1_lit", acc_data[1], lit1);
        chk("t2_gen2_lit", acc_data[2], lit2);
        chk("t2_gen3_lit", acc_data[3], lit3);
        chk("t2_steps", N'(steps - s0), N'(3));

        // 3: same job with gen1 held by backpressure
        s0 = steps;
        stall_gen = 1;
        push_job(8'd90, seed64, 3, 3);
        send_cmd("t3", 8'd90, seed64, 3);
        wait_done("t3", 2000);
        stall_gen = -1;
        chk("t3_gen1_lit", acc_data[1], lit1);
        chk("t3_steps", N'(steps - s0), N'(3));

        // 4: engine never answers; engine sees eng_step at edge E, err_timeout is set at edge E+TO
        eng_never = 1'b1;
        push_job(8'd30, seed64, 2, 0);
        send_cmd("t4", 8'd30, seed64, 2);
        ok = 1'b0;
        err_cyc = 0;
        for (int i = 0; i < TO + 300; i++) begin
            @(negedge clk);
            if (ifc.err_timeout) begin
                ok = 1'b1;
                err_cyc = cyc;
                break;
            end
        end
        chk("t4_err_seen", N'(ok), N'(1));
        chk("t4_err_delay", N'(err_cyc - last_step_cyc), N'(TO + 1));
        chk("t4_busy", N'(ifc.busy), '0);
        chk("t4_row_valid", N'(ifc.row_valid), '0);
        @(posedge clk);
        #1;
        eng_never = 1'b0;
        tick(5);
        chk("t4_err_sticky", N'(ifc.err_timeout), N'(1));
        chk("t4_no_extra_row", N'(exp_q.size()), '0);
        push_job(8'd182, seed64, 0, 0);
        send_cmd("t4b", 8'd182, seed64, 0);
        wait_done("t4b", 50);

        // 5a: abort while waiting for the engine, then stray eng_done in IDLE
        s0 = steps;
        push_job(8'd90, seed64, 3, 0);
        send_cmd("t5a", 8'd90, seed64, 3);
        wait_steps("t5a", s0 + 1, 50);
        tick(10);
        pulse_abort_and_check("t5a_abort");
        tick(150);
        stray_req++;
        tick(3);
        @(negedge clk);
        chk("t5a_stray_busy", N'(ifc.busy), '0);
        chk("t5a_stray_valid", N'(ifc.row_valid), '0);
        @(posedge clk);
        #1;
        s0 = steps;
        push_job(8'd30, seed64, 2, 2);
        send_cmd("t5a_next", 8'd30, seed64, 2);
        wait_done("t5a_next", 1000);
        chk("t5a_next_steps", N'(steps - s0), N'(2));

        // 5b: abort while a row is being held in EMIT
        s0 = steps;
        stall_gen = 0;
        push_job(8'd30, seed64, 2, 2);
        send_cmd("t5b", 8'd30, seed64, 2);
        tick(5);
        pulse_abort_and_check("t5b_abort");
        stall_gen = -1;
        tick(60);
        chk("t5b_no_step", N'(steps - s0), '0);
        push_job(8'd110, seed64, 2, 2);
        send_cmd("t5b_next", 8'd110, seed64, 2);
        wait_done("t5b_next", 1000);

        // 6: reset together with abort during WAIT, command held across reset
        s0 = steps;
        push_job(8'd90, seed64, 3, 0);
        send_cmd("t6", 8'd90, seed64, 3);
        wait_steps("t6", s0 + 1, 50);
        tick(10);
        rst           = 1'b1;
        ifc.abort     = 1'b1;
        ifc.cmd_rule  = 8'd182;
        ifc.cmd_seed  = seed6;
        ifc.cmd_gens  = GW'(1);
        ifc.cmd_valid = 1'b1;
        exp_q.delete();
        tick(1);
        rst       = 1'b0;
        ifc.abort = 1'b0;
        push_job(8'd182, seed6, 1, 1);
        @(negedge clk);
        chk_reset_outputs("t6_rst");
        @(posedge clk);
        #1;
        ifc.cmd_valid = 1'b0;
        @(negedge clk);
        chk("t6_load", N'(ifc.eng_load), N'(1));
        @(negedge clk);
        chk("t6_valid", N'(ifc.row_valid), N'(1));
        @(posedge clk);
        #1;
        wait_done("t6", 500);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1);
    end
endmodule
